// File: rtl/bcd_conv_arbiter.sv
// rtl/bcd_conv_arbiter.sv - shared round-robin arbitrated sequential binary-to-BCD converter
//
// Purpose: accepts one of N_REQ requesters round-robin, samples its operand,
// converts it with a one-bit-per-clock shift-and-add-3 loop, then returns the
// packed BCD result tagged with the requester index.
//
// Ports:
//   clk      - system clock, rising edge
//   rst      - asynchronous active-high reset
//   req      - per-requester level request, held until ack
//   bin_flat - operands, requester k at bin_flat[k*WIDTH +: WIDTH]
//   ack      - one-hot one-cycle accept pulse
//   busy     - conversion in progress
//   done     - one-cycle pulse, bcd/done_id valid
//   done_id  - requester index of the result on bcd
//   bcd      - packed BCD result, LS digit in [3:0], held until next done
module bcd_conv_arbiter #(
  parameter int N_REQ  = 3,
  parameter int ID_W   = 2,
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   bin_flat,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [4*DIGITS-1:0]      bcd
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   cur;
  logic [CNT_W-1:0]  count;
  logic [WIDTH-1:0]  sh;
  logic [ACC_W-1:0]  acc;

  logic [ID_W-1:0]   grant;
  logic              found;
  logic [ID_W-1:0]   idx;
  int                pos;
  logic [WIDTH-1:0]  sel_bin;
  logic [ACC_W-1:0]  adj;
  logic [ACC_W-1:0]  acc_next;
  logic [WIDTH-1:0]  sh_next;

  // Round-robin pick: scan from the requester after the last grant, wrapping,
  // so the most recently served requester has lowest priority.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      pos = int'(ptr) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      idx = ID_W'(pos);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    sel_bin = bin_flat[grant*WIDTH +: WIDTH];
  end

  // Double-dabble step: per-digit add-3 (no inter-digit carry), then shift the
  // operand MSB into the accumulator LSB. The adjusted top bit falls off, which
  // cannot lose information because 10^DIGITS exceeds the operand range.
  always_comb begin
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      else                        adj[4*d +: 4] = acc[4*d +: 4];
    end
    acc_next = ACC_W'({adj, sh[WIDTH-1]});
    sh_next  = {sh[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ack     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      bcd     <= '0;
      count   <= '0;
      ptr     <= ID_W'(N_REQ - 1);
      cur     <= '0;
      sh      <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          ack  <= '0;
          if (found) begin
            sh         <= sel_bin;
            acc        <= '0;
            ack[grant] <= 1'b1;
            ptr        <= grant;
            cur        <= grant;
            count      <= '0;
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          ack   <= '0;
          acc   <= acc_next;
          sh    <= sh_next;
          count <= count + 1'b1;
          if (count == CNT_W'(WIDTH - 1)) begin
            bcd     <= acc_next;
            done    <= 1'b1;
            done_id <= cur;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb/tb_bcd_conv_arbiter.sv - self-checking bench for bcd_conv_arbiter
module tb_bcd_conv_arbiter;

  localparam int N_REQ  = 3;
  localparam int ID_W   = 2;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] bin_flat;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [4*DIGITS-1:0]    bcd;

  bcd_conv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .req(req), .bin_flat(bin_flat),
    .ack(ack), .busy(busy), .done(done), .done_id(done_id), .bcd(bcd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit drop = 1'b1;

  // reference model state
  logic [N_REQ-1:0]    m_ack;
  bit                  m_busy, m_done;
  int                  m_left, m_ptr, m_cur, m_val, m_id;
  logic [4*DIGITS-1:0] m_bcd;

  // observations from the latest step
  logic [N_REQ-1:0]    obs_ack;
  bit                  obs_done;
  logic [4*DIGITS-1:0] obs_bcd;
  int                  obs_id, obs_cyc;
  int                  ack_log[$];
  int                  ack_cyc[$];
  int                  done_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Transaction-level model: one conversion in flight, result ready WIDTH
  // clocks after the accept, computed with decimal arithmetic.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack = '0; m_busy = 0; m_done = 0; m_left = 0;
      m_ptr = N_REQ - 1; m_cur = 0; m_val = 0; m_id = 0; m_bcd = '0;
    end else begin
      m_ack  = '0;
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_bcd  = to_bcd(m_val);
          m_id   = m_cur;
        end
      end else if (req != 0) begin
        for (int i = 1; i <= N_REQ; i++) begin
          if (req[(m_ptr + i) % N_REQ]) begin
            m_cur = (m_ptr + i) % N_REQ;
            break;
          end
        end
        m_val        = int'(bin_flat[m_cur*WIDTH +: WIDTH]);
        m_ack[m_cur] = 1'b1;
        m_ptr        = m_cur;
        m_busy       = 1;
        m_left       = WIDTH;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    check("ack", 32'(ack), 32'(m_ack));
    check("busy", 32'(busy), 32'(m_busy));
    check("done", 32'(done), 32'(m_done));
    check("bcd", 32'(bcd), 32'(m_bcd));
    check("done_id", 32'(done_id), 32'(m_id));
    obs_ack  = ack;
    obs_done = done;
    obs_bcd  = bcd;
    obs_id   = int'(done_id);
    obs_cyc  = cyc;
    if (ack != 0) begin
      ack_log.push_back(onehot_idx(ack));
      ack_cyc.push_back(cyc);
    end
    if (done) done_log.push_back(int'(bcd));
    if (drop) req = req & ~ack;
    cyc++;
  endtask

  task automatic wait_ack(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (obs_ack != 0) return;
    end
    check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (obs_done) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic set_op(input int k, input int v);
    bin_flat[k*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ack_log.delete();
    ack_cyc.delete();
    done_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int vals[3];
    int exps[3];
    int n1;
    rst = 1'b1;
    req = '0;
    bin_flat = '0;
    step();
    step();
    check("reset_bcd", 32'(bcd), 32'h0);
    rst = 1'b0;

    // maximum operand on requester 0
    set_op(0, 255);
    req = 3'b001;
    wait_ack(5);
    check("p1_ack", 32'(obs_ack), 32'b001);
    t = obs_cyc;
    wait_done(12);
    check("p1_latency", 32'(obs_cyc - t), 32'd8);
    check("p1_bcd", 32'(obs_bcd), 32'h255);
    check("p1_id", 32'(obs_id), 32'd0);

    // requester 1 single operands
    vals = '{0, 99, 128};
    exps = '{'h000, 'h099, 'h128};
    for (int i = 0; i < 3; i++) begin
      set_op(1, vals[i]);
      req = 3'b010;
      wait_ack(5);
      wait_done(12);
      check("p2_bcd", 32'(obs_bcd), 32'(exps[i]));
      check("p2_id", 32'(obs_id), 32'd1);
    end

    // all three requesting at once, each dropping after its ack
    pulse_reset();
    set_op(0, 123); set_op(1, 45); set_op(2, 200);
    req = 3'b111;
    repeat (32) step();
    check("p3_nacks", 32'(ack_log.size()), 32'd3);
    check("p3_ndone", 32'(done_log.size()), 32'd3);
    if (ack_log.size() == 3 && done_log.size() == 3) begin
      check("p3_order0", 32'(ack_log[0]), 32'd0);
      check("p3_order1", 32'(ack_log[1]), 32'd1);
      check("p3_order2", 32'(ack_log[2]), 32'd2);
      check("p3_gap01", 32'(ack_cyc[1] - ack_cyc[0]), 32'd9);
      check("p3_gap12", 32'(ack_cyc[2] - ack_cyc[1]), 32'd9);
      check("p3_res0", 32'(done_log[0]), 32'h123);
      check("p3_res1", 32'(done_log[1]), 32'h045);
      check("p3_res2", 32'(done_log[2]), 32'h200);
    end

    // fairness: 0 and 2 held high
    pulse_reset();
    drop = 1'b0;
    req = 3'b101;
    repeat (46) step();
    n1 = 0;
    foreach (ack_log[i]) if (ack_log[i] == 1) n1++;
    check("p4_no_req1", 32'(n1), 32'd0);
    check("p4_enough", 32'(ack_log.size() >= 4), 32'd1);
    foreach (ack_log[i]) check("p4_alternate", 32'(ack_log[i]), (i % 2) ? 32'd2 : 32'd0);
    drop = 1'b1;
    req = '0;
    repeat (10) step();

    // operand change after ack is ignored
    set_op(0, 57);
    req = 3'b001;
    wait_ack(5);
    set_op(0, 200);
    wait_done(12);
    check("p5_bcd", 32'(obs_bcd), 32'h057);

    // reset in the middle of a conversion
    set_op(0, 77);
    req = 3'b001;
    wait_ack(5);
    repeat (3) step();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("p6_ack", 32'(ack), 32'd0);
    check("p6_busy", 32'(busy), 32'd0);
    check("p6_done", 32'(done), 32'd0);
    check("p6_bcd", 32'(bcd), 32'd0);
    step();
    rst = 1'b0;
    set_op(1, 33);
    req = 3'b010;
    wait_ack(5);
    check("p6_first", 32'(obs_ack), 32'b010);
    wait_done(12);
    check("p6_res", 32'(obs_bcd), 32'h033);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) req = req | N_REQ'($urandom);
      if ($urandom_range(1) == 0) bin_flat = (N_REQ*WIDTH)'($urandom);
      drop = ($urandom_range(9) != 0);
      if (i == 300) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
